// File: rtl/sd_cmd_path.sv
// SD command-line engine: serialises a 48-bit command with CRC7 on CMD, then
// optionally captures and checks a 48- or 136-bit response, all on SDCLK.
module sd_cmd_path #(
    parameter int NcrMax    = 64,
    parameter int NccCycles = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [5:0]   cmd_index_i,
    input  logic [31:0]  cmd_arg_i,
    input  logic [1:0]   resp_type_i,
    input  logic         cmd_i,
    output logic         cmd_o,
    output logic         cmd_oe_o,
    output logic         busy_o,
    output logic         done_o,
    output logic [119:0] resp_o,
    output logic         timeout_err_o,
    output logic         crc_err_o,
    output logic         end_err_o,
    output logic         index_err_o,
    output logic [2:0]   dbg_state_o
);

    typedef enum logic [2:0] {ST_IDLE, ST_TX, ST_WAIT, ST_RX, ST_GAP} state_e;

    localparam logic [7:0] NCR_LAST = 8'(NcrMax - 1);
    localparam logic [7:0] NCC_LAST = 8'(NccCycles - 1);

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    state_e         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [38:0]    frame_q, frame_d;
    logic [5:0]     index_q, index_d;
    logic [1:0]     type_q, type_d;
    logic [6:0]     crc_q, crc_d;
    logic [133:0]   sr_q, sr_d;
    logic           cmd_q, cmd_d, oe_q, oe_d, busy_q, busy_d, done_q, done_d;
    logic [119:0]   resp_q, resp_d;
    logic           tmo_q, tmo_d, crc_err_q, crc_err_d;
    logic           end_err_q, end_err_d, idx_err_q, idx_err_d;

    logic           is_long, rx_last, rx_crc_en;
    logic [134:0]   rx_full;

    assign is_long   = (type_q == 2'd2);
    assign rx_last   = (state_q == ST_RX) && (cnt_q == (is_long ? 8'd134 : 8'd46));
    // Long responses exclude the start/transmission/reserved byte from the CRC.
    assign rx_crc_en = is_long ? (cnt_q >= 8'd7 && cnt_q <= 8'd126) : (cnt_q <= 8'd38);
    assign rx_full   = {sr_q, cmd_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start_i) state_d = ST_TX;
            ST_TX:   if (cnt_q == 8'd47) state_d = (type_q == 2'd0) ? ST_GAP : ST_WAIT;
            ST_WAIT: begin
                if (!cmd_i)                 state_d = ST_RX;
                else if (cnt_q == NCR_LAST) state_d = ST_GAP;
            end
            ST_RX:   if (rx_last) state_d = ST_GAP;
            ST_GAP:  if (cnt_q == NCC_LAST) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = (state_d != state_q || state_q == ST_IDLE) ? 8'd0 : cnt_q + 8'd1;
        frame_d   = frame_q;
        index_d   = index_q;
        type_d    = type_q;
        crc_d     = crc_q;
        sr_d      = sr_q;
        cmd_d     = 1'b1;
        oe_d      = 1'b0;
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_q == ST_GAP) && (state_d == ST_IDLE);
        resp_d    = resp_q;
        tmo_d     = tmo_q;
        crc_err_d = crc_err_q;
        end_err_d = end_err_q;
        idx_err_d = idx_err_q;
        unique case (state_q)
            ST_IDLE: if (start_i) begin
                frame_d   = {1'b1, cmd_index_i, cmd_arg_i};
                index_d   = cmd_index_i;
                type_d    = resp_type_i;
                crc_d     = 7'd0;
                tmo_d     = 1'b0;
                crc_err_d = 1'b0;
                end_err_d = 1'b0;
                idx_err_d = 1'b0;
                cmd_d     = 1'b0;
                oe_d      = 1'b1;
            end
            ST_TX: if (cnt_q < 8'd47) begin
                oe_d = 1'b1;
                if (cnt_q <= 8'd38) begin
                    cmd_d   = frame_q[38];
                    crc_d   = crc7_step(crc_q, frame_q[38]);
                    frame_d = {frame_q[37:0], 1'b0};
                end else if (cnt_q <= 8'd45) begin
                    cmd_d = crc_q[6];
                    crc_d = {crc_q[5:0], 1'b0};
                end
            end
            ST_WAIT: begin
                crc_d = 7'd0;
                if (cmd_i && cnt_q == NCR_LAST) tmo_d = 1'b1;
            end
            ST_RX: begin
                sr_d = {sr_q[132:0], cmd_i};
                if (rx_crc_en) crc_d = crc7_step(crc_q, cmd_i);
                if (rx_last) begin
                    resp_d    = is_long ? rx_full[127:8] : {88'd0, rx_full[39:8]};
                    end_err_d = !cmd_i || (!is_long && rx_full[46]);
                    crc_err_d = (type_q != 2'd3) && (rx_full[7:1] != crc_q);
                    idx_err_d = (type_q == 2'd1) && (rx_full[45:40] != index_q);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= 8'd0;
            frame_q   <= '0;
            index_q   <= '0;
            type_q    <= '0;
            crc_q     <= '0;
            sr_q      <= '0;
            cmd_q     <= 1'b1;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            resp_q    <= '0;
            tmo_q     <= 1'b0;
            crc_err_q <= 1'b0;
            end_err_q <= 1'b0;
            idx_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            frame_q   <= frame_d;
            index_q   <= index_d;
            type_q    <= type_d;
            crc_q     <= crc_d;
            sr_q      <= sr_d;
            cmd_q     <= cmd_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            resp_q    <= resp_d;
            tmo_q     <= tmo_d;
            crc_err_q <= crc_err_d;
            end_err_q <= end_err_d;
            idx_err_q <= idx_err_d;
        end
    end

    assign cmd_o         = cmd_q;
    assign cmd_oe_o      = oe_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign resp_o        = resp_q;
    assign timeout_err_o = tmo_q;
    assign crc_err_o     = crc_err_q;
    assign end_err_o     = end_err_q;
    assign index_err_o   = idx_err_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_sd_cmd_path.sv
// Directed bench for sd_cmd_path: drives commands, plays card replies on CMD
// and compares frames, status flags and completion timing with fixed values.
module tb_sd_cmd_path;

    logic         clk;
    logic         rst_ni;
    logic         start_i;
    logic [5:0]   cmd_index_i;
    logic [31:0]  cmd_arg_i;
    logic [1:0]   resp_type_i;
    logic         cmd_i;
    logic         cmd_o, cmd_oe_o, busy_o, done_o;
    logic [119:0] resp_o;
    logic         timeout_err_o, crc_err_o, end_err_o, index_err_o;
    logic [2:0]   dbg_state_o;

    int total = 0;
    int bad   = 0;

    sd_cmd_path #(.NcrMax(64), .NccCycles(8)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
        .cmd_index_i(cmd_index_i), .cmd_arg_i(cmd_arg_i), .resp_type_i(resp_type_i),
        .cmd_i(cmd_i), .cmd_o(cmd_o), .cmd_oe_o(cmd_oe_o), .busy_o(busy_o),
        .done_o(done_o), .resp_o(resp_o), .timeout_err_o(timeout_err_o),
        .crc_err_o(crc_err_o), .end_err_o(end_err_o), .index_err_o(index_err_o),
        .dbg_state_o(dbg_state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference CRC7 (x^7+x^3+1) over a 120-bit CID payload, MSB first.
    function automatic logic [6:0] crc7_120(input logic [119:0] d);
        logic [6:0]   c;
        logic [119:0] s;
        logic         fb;
        c = 7'd0;
        s = d;
        for (int i = 0; i < 120; i++) begin
            fb = s[119] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
            s  = s << 1;
        end
        return c;
    endfunction

    // Launches one command; cycle 1 is the cycle after the edge that samples start_i.
    // The reply (len bits, right-aligned) is driven on CMD starting at cycle s.
    task automatic run_txn(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ,
                           input logic [135:0] reply, input int len, input int s, input int abort_at,
                           output logic [47:0] frame, output int done_cyc,
                           output logic oe1, output logic busy1, output logic oe49,
                           output logic busy_at_done);
        logic [135:0] rsh;
        int           done_cnt;
        frame        = '0;
        done_cyc     = -1;
        oe1          = 1'b0;
        busy1        = 1'b0;
        oe49         = 1'b1;
        busy_at_done = 1'b1;
        rsh          = reply << (136 - len);
        @(negedge clk);
        cmd_index_i = idx;
        cmd_arg_i   = arg;
        resp_type_i = typ;
        start_i     = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (c <= 48) frame = {frame[46:0], cmd_o};
            if (c == 1) begin
                oe1   = cmd_oe_o;
                busy1 = busy_o;
            end
            if (c == 49) oe49 = cmd_oe_o;
            if (done_o) begin
                done_cyc     = c;
                busy_at_done = busy_o;
                break;
            end
            if (abort_at != 0 && c == abort_at) begin
                rst_ni = 1'b0;
                #1;
                check("abort_oe", cmd_oe_o, 1'b0);
                check("abort_busy", busy_o, 1'b0);
                check("abort_cmd", cmd_o, 1'b1);
                check("abort_resp", resp_o, 120'd0);
                done_cnt = 0;
                cmd_i    = 1'b1;
                repeat (20) begin
                    @(negedge clk);
                    if (done_o) done_cnt++;
                end
                check("abort_no_done", done_cnt, 0);
                rst_ni = 1'b1;
                break;
            end
            if (len > 0 && c >= s && c < s + len) begin
                cmd_i = rsh[135];
                rsh   = rsh << 1;
            end else begin
                cmd_i = 1'b1;
            end
        end
        cmd_i = 1'b1;
    endtask

    task automatic check_flags(input string tag, input logic [3:0] exp);
        check(tag, {timeout_err_o, crc_err_o, end_err_o, index_err_o}, exp);
    endtask

    logic [47:0]  frame;
    int           dcyc;
    logic         oe1, busy1, oe49, bad_busy;
    logic [119:0] cid;
    logic [135:0] cid_frame;

    initial begin
        rst_ni      = 1'b0;
        start_i     = 1'b0;
        cmd_index_i = '0;
        cmd_arg_i   = '0;
        resp_type_i = '0;
        cmd_i       = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cmd", cmd_o, 1'b1);
        check("rst_oe", cmd_oe_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_resp", resp_o, 120'd0);
        check_flags("rst_flags", 4'b0000);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);

        // CMD0, no response
        run_txn(6'd0, 32'h0, 2'd0, '0, 0, 0, 0, frame, dcyc, oe1, busy1, oe49, bad_busy);
        check("cmd0_frame", frame, 48'h400000000095);
        check("cmd0_oe1", oe1, 1'b1);
        check("cmd0_busy1", busy1, 1'b1);
        check("cmd0_oe49", oe49, 1'b0);
        check("cmd0_done", dcyc, 57);
        check("cmd0_busy_done", bad_busy, 1'b0);
        check_flags("cmd0_flags", 4'b0000);

        // CMD8 with good R7 reply
        run_txn(6'd8, 32'h1AA, 2'd1, {88'd0, 48'h08000001AA13}, 48, 51, 0,
                frame, dcyc, oe1, busy1, oe49, bad_busy);
        check("cmd8_frame", frame, 48'h48000001AA87);
        check("cmd8_oe49", oe49, 1'b0);
        check("cmd8_resp", resp_o, 120'h000001AA);
        check("cmd8_done", dcyc, 107);
        check_flags("cmd8_flags", 4'b0000);

        // Bad CRC
        run_txn(6'd8, 32'h1AA, 2'd1, {88'd0, 48'h08000001AA15}, 48, 51, 0,
                frame, dcyc, oe1, busy1, oe49, bad_busy);
        check_flags("crc_flags", 4'b0100);
        check("crc_resp", resp_o, 120'h000001AA);
        check("crc_done", dcyc, 107);

        // Wrong index echoed
        run_txn(6'd8, 32'h1AA, 2'd1, {88'd0, 48'h09000001AA13}, 48, 51, 0,
                frame, dcyc, oe1, busy1, oe49, bad_busy);
        check("idx_err", index_err_o, 1'b1);
        check("idx_end", end_err_o, 1'b0);
        check("idx_tmo", timeout_err_o, 1'b0);

        // Same reply as R3: no index/CRC checks
        run_txn(6'd8, 32'h1AA, 2'd3, {88'd0, 48'h09000001AA13}, 48, 51, 0,
                frame, dcyc, oe1, busy1, oe49, bad_busy);
        check_flags("r3_flags", 4'b0000);
        check("r3_resp", resp_o, 120'h000001AA);

        // Card silent: timeout
        run_txn(6'd8, 32'h1AA, 2'd1, '0, 0, 0, 0, frame, dcyc, oe1, busy1, oe49, bad_busy);
        check_flags("tmo_flags", 4'b1000);
        check("tmo_done", dcyc, 121);

        // Start bit on the last WAIT sample
        run_txn(6'd8, 32'h1AA, 2'd1, {88'd0, 48'h08000001AA13}, 48, 112, 0,
                frame, dcyc, oe1, busy1, oe49, bad_busy);
        check_flags("late_flags", 4'b0000);
        check("late_done", dcyc, 168);

        // 136-bit CID response
        cid       = 120'h035344534430328012345678001234;
        cid_frame = {8'h3F, cid, crc7_120(cid), 1'b1};
        run_txn(6'd2, 32'h0, 2'd2, cid_frame, 136, 50, 0, frame, dcyc, oe1, busy1, oe49, bad_busy);
        check("cid_resp", resp_o, cid);
        check_flags("cid_flags", 4'b0000);
        check("cid_done", dcyc, 194);

        // Reset asserted mid-RX
        run_txn(6'd2, 32'h0, 2'd2, cid_frame, 136, 50, 100, frame, dcyc, oe1, busy1, oe49, bad_busy);
        check("abort_dcyc", dcyc, -1);
        repeat (2) @(negedge clk);

        // Normal operation afterwards
        run_txn(6'd0, 32'h0, 2'd0, '0, 0, 0, 0, frame, dcyc, oe1, busy1, oe49, bad_busy);
        check("post_frame", frame, 48'h400000000095);
        check("post_done", dcyc, 57);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sd_cmd_path.md
# sd_cmd_path

SD command-line engine clocked by the divided SDCLK. It serialises a 48-bit command frame (with CRC7) onto CMD, then optionally captures a 48-bit or 136-bit response and checks its start, end, index and CRC fields. It sits downstream of the SDCLK divider and upstream of the host-side register and interrupt logic. All results are reported through registered status outputs.

## Interface
- `NcrMax`, default 64: maximum number of SDCLK cycles to wait for the response start bit.
- `NccCycles`, default 8: idle cycles enforced after each transaction.
- `clk_i` in 1: SDCLK from the clock divider; the only clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `start_i` in 1: pulse that launches a command; sampled only in IDLE.
- `cmd_index_i` in 6: command index.
- `cmd_arg_i` in 32: command argument.
- `resp_type_i` in 2: response type.
  - 0: none.
  - 1: 48-bit, check CRC and index.
  - 2: 136-bit.
  - 3: 48-bit, no CRC or index check (R3).
- `cmd_i` in 1: sampled CMD line.
- `cmd_o` out 1: CMD drive value.
- `cmd_oe_o` out 1: CMD output enable.
- `busy_o` out 1: transaction in progress.
- `done_o` out 1: one-cycle completion pulse.
- `resp_o` out 120: captured response content.
  - 48-bit responses: bits [39:8] in `resp_o[31:0]`, upper bits zero.
  - 136-bit responses: bits [127:8] in `resp_o[119:0]`.
- `timeout_err_o`, `crc_err_o`, `end_err_o`, `index_err_o` out 1 each: error flags.

## Operation
- States: IDLE, TX, WAIT, RX, GAP.
- **IDLE**
  - `cmd_oe_o`=0, `cmd_o`=1, `busy_o`=0.
  - On `start_i`: latch index, argument and type; clear all error flags; go to TX.
- **TX:** shift out 48 bits, MSB first, one bit per cycle.
  - Bit 47: start bit, 0.
  - Bit 46: transmission bit, 1.
  - Bits [45:40]: index.
  - Bits [39:8]: argument.
  - Bits [7:1]: CRC7.
  - Bit 0: end bit, 1.
  - CRC7 uses polynomial x^7+x^3+1 with initial value 0, computed serially over bits 47..8 as they are shifted.
  - After bit 0: go to GAP if type is 0, otherwise to WAIT.
- **WAIT**
  - `cmd_oe_o`=0; sample `cmd_i` each cycle.
  - `cmd_i`=0 marks the response start bit: go to RX.
  - `NcrMax` samples all 1: set `timeout_err_o` and go to GAP.
- **RX**
  - Shift in the remaining 47 bits (types 1/3) or 135 bits (type 2).
  - CRC7 coverage:
    - 48-bit responses: bits 47..8.
    - 136-bit responses: bits 127..8; bits 135..128 are excluded.
  - Checks on the last bit, each setting its own flag:
    - End bit ≠1 sets `end_err_o`.
    - Received CRC ≠ computed CRC sets `crc_err_o`; skipped for type 3.
    - Types 1 and 3: transmission bit ≠0 sets `end_err_o`.
    - Type 1 only: index ≠ the sent index sets `index_err_o`.
  - Load `resp_o` on the last bit, even when errors are set; otherwise `resp_o` holds its previous value.
  - Then go to GAP.
- **GAP**
  - `cmd_oe_o`=0.
  - After `NccCycles` cycles: enter IDLE and pulse `done_o`.
- `start_i` outside IDLE is ignored.
- Error flags hold until the next accepted `start_i`.

## Timing
- Reset values: `cmd_o`=1, `cmd_oe_o`=0, `busy_o`=0, `done_o`=0, `resp_o`=0, all error flags 0, state IDLE.
- All outputs are registered.
- Let `start_i` be sampled high in IDLE at edge 0:
  - `busy_o`=1 and `cmd_oe_o`=1 from cycle 1.
  - Cycles 1..48 drive bits 47..0.
  - Cycle 49: `cmd_oe_o`=0.
- Type 0: GAP occupies cycles 49..56; `done_o`=1 and `busy_o`=0 at cycle 57.
- WAIT samples cycles 49..(48+`NcrMax`).
  - A start bit sampled at cycle s puts the last response bit at s+47 (48-bit) or s+135 (136-bit).
  - GAP follows for 8 cycles; `done_o` occurs at last+9.
- Timeout: GAP starts at cycle 113; `done_o` at cycle 121.
- Asynchronous reset mid-transaction: immediately return to IDLE and release CMD; no `done_o`.
- A start bit on the final WAIT sample is accepted, not a timeout.

## Test plan
- CMD0, arg 0x00000000, type 0 → CMD frame 0x400000000095; `done_o` at cycle 57; no error flags.
- CMD8, arg 0x000001AA, type 1 → frame 0x48000001AA87.
  - Bench replies 0x08000001AA13 with start bit at cycle 51.
  - Required: `resp_o[31:0]`=0x000001AA, no errors, `done_o` at cycle 107.
- CMD8 with reply 0x08000001AA15 → `crc_err_o`=1 only.
- CMD8 with reply 0x09000001AA… (index 9) → `index_err_o`=1.
  - Same reply with type 3 and a bad CRC → no errors.
- Type 1, CMD held high → `timeout_err_o`=1 and `done_o` at cycle 121.
  - Start bit at cycle 112 → accepted, no timeout.
- Type 2 with a 136-bit CID frame whose CRC is correct → `resp_o` equals bits [127:8].
  - Assert `rst_ni` low mid-RX → `cmd_oe_o`=0, `busy_o`=0, no `done_o`.
  - A following `start_i` works normally.
